blob_frame_ctrl: RTL

- Per-frame scheduler for the Grayscale -> Blob pipeline.
- Waits for a captured frame to land in SDRAM, then pulses Grayscale start and holds the camera writer off.
- Counts streamed pixels, waits for the Blob result, latches the blob count and reports done, timeout or protocol errors.
- Supports continuous and single-shot operation, with optional frame decimation.

---
 rtl/blob_frame_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/blob_frame_ctrl.sv
// Per-frame scheduler for the Grayscale -> Blob pipeline: arms on a capture, launches Grayscale,
// counts pixels, waits for the blob result. Optional latency stats: define BLOB_FRAME_CTRL_STATS_EN.
// state  | meaning
// IDLE   | not armed; waits for i_single or i_enable
// ARM    | waiting for the DECIM-th i_frame_done
// START  | one-cycle Grayscale start pulse, counters cleared
// STREAM | counting binarized pixels up to N
// DRAIN  | all pixels seen, waiting for the blob result
// DONE   | result latched, o_done pulse
// ERR    | timeout or protocol fault, one cycle then IDLE
module blob_frame_ctrl #(
   parameter int IMG_COL     = 640,
   parameter int IMG_ROW     = 480,
   parameter int COUNT_W     = 8,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int DECIM       = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_enable,
   input  logic               i_single,
   input  logic               i_frame_done,
   output logic               o_gray_start,
   output logic               o_cap_hold,
   input  logic               i_pix_valid,
   input  logic               i_blob_valid,
   input  logic [COUNT_W-1:0] i_blob_count,
   output logic               o_busy,
   output logic               o_done,
   output logic [COUNT_W-1:0] o_count,
   output logic [15:0]        o_frame_cnt,
   output logic               o_skip,
   output logic [1:0]         o_err,
   output logic [23:0]        o_last_cycles
);

   localparam int PIX_W = 19;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMG_COL * IMG_ROW - 1);
   localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYC);
   localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_START, S_STREAM, S_DRAIN, S_DONE, S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic               one_shot_q, one_shot_d;
   logic [DEC_W-1:0]   dec_q, dec_d;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [1:0]         err_q, err_d, err_set;
   logic               gray_start, done, skip;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         one_shot_q  <= 1'b0;
         dec_q       <= '0;
         pix_q       <= '0;
         tmo_q       <= '0;
         count_q     <= '0;
         frame_cnt_q <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         one_shot_q  <= one_shot_d;
         dec_q       <= dec_d;
         pix_q       <= pix_d;
         tmo_q       <= tmo_d;
         count_q     <= count_d;
         frame_cnt_q <= frame_cnt_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      one_shot_d  = one_shot_q;
      dec_d       = dec_q;
      pix_d       = pix_q;
      tmo_d       = tmo_q;
      count_d     = count_q;
      frame_cnt_d = frame_cnt_q;
      err_set     = 2'b00;
      gray_start  = 1'b0;
      done        = 1'b0;
      skip        = 1'b0;
      tmo_inc     = tmo_q + TMO_W'(1);
      case (state_q)
         S_IDLE: begin
            if (i_single || i_enable) begin
               state_d    = S_ARM;
               one_shot_d = i_single & ~i_enable;
            end
         end
         S_ARM: begin
            if (!i_enable && !one_shot_q) begin
               state_d = S_IDLE;
            end else if (i_frame_done) begin
               if (dec_q == DEC_LAST) begin
                  dec_d   = '0;
                  state_d = S_START;
               end else begin
                  dec_d = dec_q + DEC_W'(1);
                  skip  = 1'b1;
               end
            end
         end
         S_START: begin
            gray_start = 1'b1;
            skip       = i_frame_done;
            pix_d      = '0;
            // the START cycle itself counts toward the timeout window
            tmo_d      = TMO_W'(1);
            state_d    = S_STREAM;
         end
         S_STREAM: begin
            skip  = i_frame_done;
            tmo_d = tmo_inc;
            if (i_blob_valid) begin
               err_set[1] = 1'b1;
               state_d    = S_ERR;
            end else if (tmo_inc >= TMO_LIM) begin
               err_set[0] = 1'b1;
               state_d    = S_ERR;
            end else if (i_pix_valid) begin
               pix_d = pix_q + PIX_W'(1);
               if (pix_q == PIX_LAST) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            skip  = i_frame_done;
            tmo_d = tmo_inc;
            if (i_blob_valid) begin
               count_d     = i_blob_count;
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = S_DONE;
            end else if (tmo_inc >= TMO_LIM) begin
               err_set[0] = 1'b1;
               state_d    = S_ERR;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            skip       = i_frame_done;
            one_shot_d = 1'b0;
            state_d    = i_enable ? S_ARM : S_IDLE;
         end
         S_ERR: begin
            one_shot_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      err_d = (i_single ? 2'b00 : err_q) | err_set;
   end

   assign o_busy       = (state_q == S_START) || (state_q == S_STREAM) ||
                         (state_q == S_DRAIN) || (state_q == S_DONE);
   assign o_cap_hold   = o_busy;
   assign o_gray_start = gray_start;
   assign o_done       = done;
   assign o_skip       = skip;
   assign o_count      = count_q;
   assign o_frame_cnt  = frame_cnt_q;
   assign o_err        = err_q;

`ifdef BLOB_FRAME_CTRL_STATS_EN
   logic [23:0] cyc_q, cyc_d, cyc_inc, last_q, last_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cyc_q  <= '0;
         last_q <= '0;
      end else begin
         cyc_q  <= cyc_d;
         last_q <= last_d;
      end
   end

   always_comb begin
      cyc_inc = (cyc_q == 24'hFF_FFFF) ? cyc_q : cyc_q + 24'd1;
      cyc_d   = cyc_q;
      last_d  = last_q;
      if (state_q == S_START) cyc_d = 24'd1;
      else if (state_q == S_STREAM || state_q == S_DRAIN) cyc_d = cyc_inc;
      if (state_q == S_DRAIN && i_blob_valid) last_d = cyc_inc;
   end

   assign o_last_cycles = last_q;
`else
   assign o_last_cycles = 24'd0;
`endif

endmodule
